fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline; drives fetch_decode_pipe (PCounterF, InstrF, PCPlus4F).

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch stage: architectural
//   width, the canonical NOP instruction (addi x0,x0,0), the fetch-queue
//   entry layout and a word-alignment helper.
package fetch_pkg;

  localparam int XLEN = 32;

  // Shown on InstrF whenever no valid head entry exists.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the two low address bits so every request is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   Small FIFO of fetch_entry_t that decouples instruction-memory responses
//   from decode back-pressure. Head is read combinationally from registered
//   storage, so a word pushed at the end of a cycle is visible next cycle.
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   push, push_data   write one entry at the end of this cycle
//   pop               retire the head entry at the end of this cycle
//   flush             discard all entries (wins over push and pop)
//   count             number of valid entries
//   head_valid, head  oldest entry and its valid flag
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(QDEPTH):0]      count,
  output logic                         head_valid,
  output fetch_entry_t                 head
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t      entry_reg [QDEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  logic              full;
  logic              do_pop;
  logic              do_push;

  assign full    = (count_reg == CW'(QDEPTH));
  assign do_pop  = pop & (count_reg != '0);
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset: it is only observed through head_valid.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && !flush && (wr_ptr_reg == AW'(gi))) begin
          entry_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head       = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   IF stage of the 5-stage RV32I pipeline. Owns the PC, issues sequential
//   word requests to a synchronous-read instruction memory (1-cycle latency),
//   buffers responses in fetch_queue and applies EX-stage redirects. An epoch
//   bit tags each request so responses from a squashed path are dropped.
// Ports
//   clk, rst_n            clock / asynchronous active-low reset
//   stallF                hold the queue head (no pop)
//   PCSrcE, PCTargetE     redirect strobe and target from EX
//   imem_req, imem_addr   read request and word-aligned address
//   imem_rdata            data for the request issued the previous cycle
//   ValidF                head entry valid
//   PCounterF, InstrF     PC and instruction of the head entry (0 / NOP if invalid)
//   PCPlus4F              PCounterF + 4
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                   DATA_WIDTH = XLEN,
  parameter logic [XLEN-1:0]      RESET_PC   = 32'h0,
  parameter int                   QDEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stallF,
  input  logic                    PCSrcE,
  input  logic [DATA_WIDTH-1:0]   PCTargetE,
  output logic                    imem_req,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    ValidF,
  output logic [DATA_WIDTH-1:0]   PCounterF,
  output logic [DATA_WIDTH-1:0]   InstrF,
  output logic [DATA_WIDTH-1:0]   PCPlus4F
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [DATA_WIDTH-1:0]  pc_reg;
  logic [DATA_WIDTH-1:0]  inflight_pc_reg;
  logic                   inflight_reg;
  logic                   inflight_epoch_reg;
  logic                   epoch_reg;

  logic [CW-1:0]          q_count;
  logic                   q_valid;
  fetch_entry_t           q_head;
  fetch_entry_t           q_push_data;
  logic                   q_push;
  logic                   pop;
  logic                   issue;
  logic [CW:0]            occupancy;

  // A redirect squashes the displayed head instead of consuming it.
  assign pop = q_valid & ~stallF & ~PCSrcE;

  // Credit check: entries held plus the response still in flight, less the
  // entry leaving now, must leave room for the word requested this cycle.
  assign occupancy = {1'b0, q_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  assign issue     = rst_n & ~PCSrcE & (occupancy < (CW+1)'(QDEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_reg;

  // Only responses fetched in the current epoch are kept.
  assign q_push           = inflight_reg & (inflight_epoch_reg == epoch_reg);
  assign q_push_data.pc    = inflight_pc_reg;
  assign q_push_data.instr = imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg             <= align_word(RESET_PC);
      inflight_pc_reg    <= '0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      epoch_reg          <= 1'b0;
    end else begin
      inflight_reg       <= issue;
      inflight_epoch_reg <= epoch_reg;
      if (issue) inflight_pc_reg <= pc_reg;
      if (PCSrcE) begin
        pc_reg    <= align_word(PCTargetE);
        epoch_reg <= ~epoch_reg;
      end else if (issue) begin
        pc_reg    <= pc_reg + DATA_WIDTH'(4);
      end
    end
  end

  // Flush on redirect also discards a same-cycle response from the old path.
  fetch_queue #(
    .QDEPTH     (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_data  (q_push_data),
    .pop        (pop),
    .flush      (PCSrcE),
    .count      (q_count),
    .head_valid (q_valid),
    .head       (q_head)
  );

  assign ValidF    = q_valid;
  assign PCounterF = q_valid ? q_head.pc    : '0;
  assign InstrF    = q_valid ? q_head.instr : NOP_INSTR;
  assign PCPlus4F  = PCounterF + DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A synchronous memory model returns
//   mem[i] = i (word index) one cycle after each request. Scenario tasks push
//   the expected in-order PC stream onto a scoreboard queue; a monitor pops
//   and compares on every cycle in which the DUT retires its head entry.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ValidF;
  logic [31:0] PCounterF;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .QDEPTH     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallF     (stallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ValidF     (ValidF),
    .PCounterF  (PCounterF),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  initial imem_rdata = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  // Scoreboard monitor: one line per retired instruction.
  always @(negedge clk) begin
    if (rst_n && ValidF && !stallF && !PCSrcE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%08h, want no retire", PCounterF);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        $display("retire pc=%08h instr=%08h pc4=%08h", PCounterF, InstrF, PCPlus4F);
        if (PCounterF !== e || InstrF !== mem_word(e) || PCPlus4F !== e + 32'd4) begin
          errors++;
          $display("FAIL sb_entry: got pc=%08h instr=%08h pc4=%08h, want pc=%08h instr=%08h pc4=%08h",
                   PCounterF, InstrF, PCPlus4F, e, mem_word(e), e + 32'd4);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Hold reset two cycles, release right after an edge (that cycle is cycle 0).
  task automatic do_reset();
    rst_n  = 1'b0;
    stallF = 1'b0;
    PCSrcE = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    push_stream(32'h0, 64);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    step();
    step();
    checks++; if (ValidF !== 1'b0)         begin errors++; $display("FAIL rst_valid: got %b want 0", ValidF); end
    checks++; if (imem_req !== 1'b0)       begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (PCounterF !== 32'h0)     begin errors++; $display("FAIL rst_pc: got %08h want 0", PCounterF); end
    checks++; if (PCPlus4F !== 32'h4)      begin errors++; $display("FAIL rst_pc4: got %08h want 4", PCPlus4F); end
    checks++; if (InstrF !== NOP_INSTR)    begin errors++; $display("FAIL rst_instr: got %08h want %08h", InstrF, NOP_INSTR); end
    rst_n = 1'b1;
    exp_q.delete();
    push_stream(32'h0, 64);
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL c0_req: got req=%b addr=%08h want 1/0", imem_req, imem_addr); end
    step();
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL c1_valid: got %b want 0", ValidF); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL c1_req: got req=%b addr=%08h want 1/4", imem_req, imem_addr); end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCounterF !== 32'h0 || InstrF !== 32'h0 || PCPlus4F !== 32'h4) begin
      errors++; $display("FAIL c2_head: got v=%b pc=%08h instr=%08h pc4=%08h want 1/0/0/4", ValidF, PCounterF, InstrF, PCPlus4F);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    pc = 32'h4;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (ValidF !== 1'b1 || PCounterF !== pc) begin
        errors++; $display("FAIL stream_%0d: got v=%b pc=%08h want 1/%08h", i, ValidF, PCounterF, pc);
      end
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    bit found;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ValidF && PCounterF == 32'h8) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach8: got timeout want head pc=8"); end
    stallF = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req0: got %b want 0", imem_req); end
    for (int i = 1; i < 3; i++) begin
      step();
      checks++;
      if (ValidF !== 1'b1 || PCounterF !== 32'h8 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%08h req=%b want 1/8/0", i, ValidF, PCounterF, imem_req);
      end
    end
    step();
    stallF = 1'b0;
    #1;
    checks++;
    if (ValidF !== 1'b1 || PCounterF !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL stall_release: got v=%b pc=%08h req=%b addr=%08h want 1/8/1/10", ValidF, PCounterF, imem_req, imem_addr);
    end
    step();
    checks++; if (ValidF !== 1'b1 || PCounterF !== 32'hC)  begin errors++; $display("FAIL stall_next_c: got v=%b pc=%08h want 1/c", ValidF, PCounterF); end
    step();
    checks++; if (ValidF !== 1'b1 || PCounterF !== 32'h10) begin errors++; $display("FAIL stall_next_10: got v=%b pc=%08h want 1/10", ValidF, PCounterF); end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h14) found = 1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_reach14: got timeout want req addr=14"); end
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    exp_q.delete();
    push_stream(32'h40, 64);
    #1;
    checks++;
    if (imem_req !== 1'b0 || ValidF !== 1'b1 || PCounterF !== 32'h10) begin
      errors++; $display("FAIL redir_cycle: got req=%b v=%b pc=%08h want 0/1/10", imem_req, ValidF, PCounterF);
    end
    step();
    PCSrcE = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || ValidF !== 1'b0) begin
      errors++; $display("FAIL redir_first_req: got req=%b addr=%08h v=%b want 1/40/0", imem_req, imem_addr, ValidF);
    end
    step();
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL redir_gap: got v=%b pc=%08h want 0", ValidF, PCounterF); end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCounterF !== 32'h40 || InstrF !== 32'h10) begin
      errors++; $display("FAIL redir_target: got v=%b pc=%08h instr=%08h want 1/40/10", ValidF, PCounterF, InstrF);
    end
  endtask

  task automatic test_redirect_full();
    step();
    stallF = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || ValidF !== 1'b1) begin
      errors++; $display("FAIL full_stalled: got req=%b v=%b want 0/1", imem_req, ValidF);
    end
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    exp_q.delete();
    push_stream(32'h100, 64);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_redir_req: got %b want 0", imem_req); end
    step();
    PCSrcE = 1'b0; stallF = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || ValidF !== 1'b0) begin
      errors++; $display("FAIL full_first_req: got req=%b addr=%08h v=%b want 1/100/0", imem_req, imem_addr, ValidF);
    end
    step();
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL full_gap: got v=%b want 0", ValidF); end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCounterF !== 32'h100 || InstrF !== 32'h40) begin
      errors++; $display("FAIL full_target: got v=%b pc=%08h instr=%08h want 1/100/40", ValidF, PCounterF, InstrF);
    end
  endtask

  task automatic test_wrap();
    bit found;
    step();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    exp_q.delete();
    push_stream(32'hFFFF_FFF8, 64);
    step();
    PCSrcE = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (ValidF && PCounterF == 32'hFFFF_FFFC) found = 1;
    end
    checks++;
    if (!found || PCPlus4F !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4: got found=%0d pc4=%08h want 1/0", found, PCPlus4F);
    end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCounterF !== 32'h0 || InstrF !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: got v=%b pc=%08h instr=%08h want 1/0/0", ValidF, PCounterF, InstrF);
    end
  endtask

  task automatic test_reset_mid();
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_inflight: got req=%b want 1", imem_req); end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (ValidF !== 1'b0)      begin errors++; $display("FAIL mid_valid: got %b want 0", ValidF); end
    checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL mid_req: got %b want 0", imem_req); end
    checks++;
    if (PCounterF !== 32'h0 || PCPlus4F !== 32'h4 || InstrF !== NOP_INSTR) begin
      errors++; $display("FAIL mid_outs: got pc=%08h pc4=%08h instr=%08h want 0/4/%08h", PCounterF, PCPlus4F, InstrF, NOP_INSTR);
    end
    step();
    step();
    rst_n = 1'b1;
    push_stream(32'h0, 64);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_restart_req: got req=%b addr=%08h want 1/0", imem_req, imem_addr);
    end
    step();
    checks++; if (ValidF !== 1'b0) begin errors++; $display("FAIL mid_stale: got v=%b pc=%08h want 0", ValidF, PCounterF); end
    step();
    checks++;
    if (ValidF !== 1'b1 || PCounterF !== 32'h0) begin
      errors++; $display("FAIL mid_restart_head: got v=%b pc=%08h want 1/0", ValidF, PCounterF);
    end
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
